// File: rtl/cache_refill_engine.sv
// Refill stage behind the prefetching cache: queues demand misses and prefetches,
// merges duplicates, runs one backing-memory read at a time and returns fill pulses.
module cache_refill_engine #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 32,
    parameter int QUEUE_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miss_valid,
    input  logic [ADDR_WIDTH-1:0] miss_addr,
    output logic                  miss_ready,
    input  logic                  pf_valid,
    input  logic [ADDR_WIDTH-1:0] pf_addr,
    output logic                  pf_dropped,
    output logic                  mem_req_valid,
    output logic [ADDR_WIDTH-1:0] mem_req_addr,
    input  logic                  mem_req_ready,
    input  logic                  mem_resp_valid,
    input  logic [DATA_WIDTH-1:0] mem_resp_data,
    output logic                  fill_valid,
    output logic [ADDR_WIDTH-1:0] fill_addr,
    output logic [DATA_WIDTH-1:0] fill_data,
    output logic                  fill_is_pf,
    output logic                  busy
);

    localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_FILL
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic [ADDR_WIDTH-1:0]   q_addr [QUEUE_DEPTH];
    logic [QUEUE_DEPTH-1:0]  q_pf;
    logic [QUEUE_DEPTH-1:0]  q_pf_next;
    logic [PTR_W-1:0]        rd_ptr;
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        pf_idx;
    logic [CNT_W-1:0]        count;
    logic [CNT_W-1:0]        push_cnt;

    logic [ADDR_WIDTH-1:0]   inflight_addr;
    logic [DATA_WIDTH-1:0]   resp_data_q;
    logic                    pf_dropped_q;

    logic [QUEUE_DEPTH-1:0]  entry_valid;
    logic [QUEUE_DEPTH-1:0]  miss_hit_vec;
    logic [QUEUE_DEPTH-1:0]  pf_hit_vec;
    logic                    miss_fire;
    logic                    miss_push;
    logic                    pf_merge;
    logic                    pf_room;
    logic                    pf_push;
    logic                    pf_drop;
    logic                    pop;

    // The in-flight request stays at the queue head, so matching against the
    // live queue entries also covers the outstanding address.
    always_comb begin
        entry_valid  = '0;
        miss_hit_vec = '0;
        pf_hit_vec   = '0;
        for (int i = 0; i < QUEUE_DEPTH; i++) begin
            entry_valid[i]  = ({1'b0, PTR_W'(i) - rd_ptr}) < count;
            miss_hit_vec[i] = entry_valid[i] && (q_addr[i] == miss_addr);
            pf_hit_vec[i]   = entry_valid[i] && (q_addr[i] == pf_addr);
        end
    end

    always_comb begin
        miss_fire = miss_valid && miss_ready;
        miss_push = miss_fire && !(|miss_hit_vec);
        pf_merge  = (miss_fire && (pf_addr == miss_addr)) || (|pf_hit_vec);
        pf_room   = (count + CNT_W'(miss_push)) < CNT_W'(QUEUE_DEPTH);
        pf_push   = pf_valid && !pf_merge && pf_room;
        pf_drop   = pf_valid && !pf_merge && !pf_room;
        pop       = (state == S_FILL);
        push_cnt  = CNT_W'(miss_push) + CNT_W'(pf_push);
        pf_idx    = miss_push ? (wr_ptr + PTR_W'(1)) : wr_ptr;

        q_pf_next = q_pf;
        if (miss_fire) begin
            q_pf_next = q_pf_next & ~miss_hit_vec;
        end
        if (miss_push) begin
            q_pf_next[wr_ptr] = 1'b0;
        end
        if (pf_push) begin
            q_pf_next[pf_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                q_addr[i] <= '0;
            end
            q_pf         <= '0;
            rd_ptr       <= '0;
            wr_ptr       <= '0;
            count        <= '0;
            pf_dropped_q <= 1'b0;
        end else begin
            q_pf         <= q_pf_next;
            pf_dropped_q <= pf_drop;
            if (miss_push) begin
                q_addr[wr_ptr] <= miss_addr;
            end
            if (pf_push) begin
                q_addr[pf_idx] <= pf_addr;
            end
            wr_ptr <= wr_ptr + PTR_W'(push_cnt);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + push_cnt - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= S_IDLE;
            inflight_addr <= '0;
            resp_data_q   <= '0;
        end else begin
            state <= state_next;
            if (state == S_IDLE && count != '0) begin
                inflight_addr <= q_addr[rd_ptr];
            end
            if (state == S_WAIT && mem_resp_valid) begin
                resp_data_q <= mem_resp_data;
            end
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (count != '0)    state_next = S_REQ;
            S_REQ:   if (mem_req_ready)  state_next = S_WAIT;
            S_WAIT:  if (mem_resp_valid) state_next = S_FILL;
            S_FILL:                      state_next = S_IDLE;
            default:                     state_next = S_IDLE;
        endcase
    end

    // A demand merging into the head during its fill cycle turns it into a demand fill.
    always_comb begin
        miss_ready    = (count != CNT_W'(QUEUE_DEPTH));
        mem_req_valid = (state == S_REQ);
        mem_req_addr  = mem_req_valid ? inflight_addr : '0;
        fill_valid    = (state == S_FILL);
        fill_addr     = fill_valid ? inflight_addr : '0;
        fill_data     = fill_valid ? resp_data_q : '0;
        fill_is_pf    = fill_valid && q_pf[rd_ptr] && !(miss_fire && miss_hit_vec[rd_ptr]);
        busy          = (count != '0) || (state != S_IDLE);
        pf_dropped    = pf_dropped_q;
    end

endmodule

// File: tb/tb_cache_refill_engine.sv
// Directed self-checking bench for cache_refill_engine with a zero-wait memory responder.
module tb_cache_refill_engine;

    logic        clk;
    logic        reset;
    logic        miss_valid;
    logic [7:0]  miss_addr;
    logic        miss_ready;
    logic        pf_valid;
    logic [7:0]  pf_addr;
    logic        pf_dropped;
    logic        mem_req_valid;
    logic [7:0]  mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;
    logic        fill_valid;
    logic [7:0]  fill_addr;
    logic [31:0] fill_data;
    logic        fill_is_pf;
    logic        busy;

    int checks;
    int failures;
    int cyc;

    logic        resp_enable;
    logic        pending;
    logic [7:0]  pend_addr;

    logic [7:0]  fa_q [$];
    logic [31:0] fd_q [$];
    logic        fp_q [$];
    int          fc_q [$];

    cache_refill_engine #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (32),
        .QUEUE_DEPTH(4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .miss_valid    (miss_valid),
        .miss_addr     (miss_addr),
        .miss_ready    (miss_ready),
        .pf_valid      (pf_valid),
        .pf_addr       (pf_addr),
        .pf_dropped    (pf_dropped),
        .mem_req_valid (mem_req_valid),
        .mem_req_addr  (mem_req_addr),
        .mem_req_ready (mem_req_ready),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_data (mem_resp_data),
        .fill_valid    (fill_valid),
        .fill_addr     (fill_addr),
        .fill_data     (fill_data),
        .fill_is_pf    (fill_is_pf),
        .busy          (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_data(input logic [7:0] a);
        return (a == 8'h10) ? 32'hDEADBEEF : {24'hC0FFEE, a};
    endfunction

    // Responder answers one cycle after the request handshake.
    initial begin
        pending   = 1'b0;
        pend_addr = '0;
        forever begin
            @(negedge clk);
            if (resp_enable) begin
                mem_resp_valid = 1'b0;
                if (pending) begin
                    mem_resp_valid = 1'b1;
                    mem_resp_data  = mem_data(pend_addr);
                    pending        = 1'b0;
                end else if (mem_req_valid && mem_req_ready) begin
                    pending   = 1'b1;
                    pend_addr = mem_req_addr;
                end
            end else begin
                pending = 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (fill_valid) begin
            fa_q.push_back(fill_addr);
            fd_q.push_back(fill_data);
            fp_q.push_back(fill_is_pf);
            fc_q.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic mv, input logic [7:0] ma, input logic pv, input logic [7:0] pa);
        miss_valid = mv;
        miss_addr  = ma;
        pf_valid   = pv;
        pf_addr    = pa;
        @(posedge clk);
        #1;
        miss_valid = 1'b0;
        pf_valid   = 1'b0;
    endtask

    task automatic clear_fills();
        fa_q.delete();
        fd_q.delete();
        fp_q.delete();
        fc_q.delete();
    endtask

    task automatic wait_idle(input int budget, output logic timed_out);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        timed_out = busy;
    endtask

    task automatic test_reset();
        step();
        step();
        checks += 5;
        if (miss_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_miss_ready got=%b exp=1", miss_ready); end
        if (mem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_mem_req_valid got=%b exp=0", mem_req_valid); end
        if (fill_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_fill_valid got=%b exp=0", fill_valid); end
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy got=%b exp=0", busy); end
        if (pf_dropped !== 1'b0) begin failures++; $display("[TB] FAIL reset_pf_dropped got=%b exp=0", pf_dropped); end
        reset = 1'b0;
        step();
    endtask

    task automatic test_single_miss();
        logic to;
        int   enq;
        clear_fills();
        mem_req_ready = 1'b1;
        send(1'b1, 8'h10, 1'b0, 8'h00);
        enq = cyc;
        checks += 2;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy got=%b exp=1", busy); end
        if (mem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL single_req_early got=%b exp=0", mem_req_valid); end
        step();
        checks += 2;
        if (mem_req_valid !== 1'b1) begin failures++; $display("[TB] FAIL single_req_valid got=%b exp=1", mem_req_valid); end
        if (mem_req_addr !== 8'h10) begin failures++; $display("[TB] FAIL single_req_addr got=%h exp=10", mem_req_addr); end
        wait_idle(50, to);
        checks++;
        if (to !== 1'b0) begin failures++; $display("[TB] FAIL single_idle_timeout got=%b exp=0", to); end
        checks++;
        if (fa_q.size() != 1) begin
            failures++;
            $display("[TB] FAIL single_fill_count got=%0d exp=1", fa_q.size());
        end else begin
            checks += 4;
            if (fa_q[0] !== 8'h10) begin failures++; $display("[TB] FAIL single_fill_addr got=%h exp=10", fa_q[0]); end
            if (fd_q[0] !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL single_fill_data got=%h exp=deadbeef", fd_q[0]); end
            if (fp_q[0] !== 1'b0) begin failures++; $display("[TB] FAIL single_fill_is_pf got=%b exp=0", fp_q[0]); end
            if (fc_q[0] - enq != 3) begin failures++; $display("[TB] FAIL single_latency got=%0d exp=3", fc_q[0] - enq); end
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL single_busy_after got=%b exp=0", busy); end
    endtask

    task automatic test_miss_and_pf();
        logic to;
        clear_fills();
        mem_req_ready = 1'b1;
        send(1'b1, 8'h10, 1'b1, 8'h14);
        wait_idle(60, to);
        checks += 2;
        if (to !== 1'b0) begin failures++; $display("[TB] FAIL pair_idle_timeout got=%b exp=0", to); end
        if (fa_q.size() != 2) begin
            failures++;
            $display("[TB] FAIL pair_fill_count got=%0d exp=2", fa_q.size());
        end else begin
            checks += 5;
            if (fa_q[0] !== 8'h10) begin failures++; $display("[TB] FAIL pair_addr0 got=%h exp=10", fa_q[0]); end
            if (fp_q[0] !== 1'b0) begin failures++; $display("[TB] FAIL pair_pf0 got=%b exp=0", fp_q[0]); end
            if (fa_q[1] !== 8'h14) begin failures++; $display("[TB] FAIL pair_addr1 got=%h exp=14", fa_q[1]); end
            if (fp_q[1] !== 1'b1) begin failures++; $display("[TB] FAIL pair_pf1 got=%b exp=1", fp_q[1]); end
            if (fd_q[1] !== 32'hC0FFEE14) begin failures++; $display("[TB] FAIL pair_data1 got=%h exp=c0ffee14", fd_q[1]); end
        end
        clear_fills();
        send(1'b1, 8'h70, 1'b1, 8'h70);
        wait_idle(60, to);
        checks++;
        if (fa_q.size() != 1) begin
            failures++;
            $display("[TB] FAIL same_fill_count got=%0d exp=1", fa_q.size());
        end else begin
            checks += 2;
            if (fa_q[0] !== 8'h70) begin failures++; $display("[TB] FAIL same_addr got=%h exp=70", fa_q[0]); end
            if (fp_q[0] !== 1'b0) begin failures++; $display("[TB] FAIL same_pf got=%b exp=0", fp_q[0]); end
        end
    endtask

    task automatic test_merge();
        logic to;
        clear_fills();
        mem_req_ready = 1'b0;
        send(1'b0, 8'h00, 1'b1, 8'h20);
        send(1'b1, 8'h20, 1'b0, 8'h00);
        step();
        mem_req_ready = 1'b1;
        wait_idle(60, to);
        checks += 2;
        if (to !== 1'b0) begin failures++; $display("[TB] FAIL merge_idle_timeout got=%b exp=0", to); end
        if (fa_q.size() != 1) begin
            failures++;
            $display("[TB] FAIL merge_fill_count got=%0d exp=1", fa_q.size());
        end else begin
            checks += 2;
            if (fa_q[0] !== 8'h20) begin failures++; $display("[TB] FAIL merge_addr got=%h exp=20", fa_q[0]); end
            if (fp_q[0] !== 1'b0) begin failures++; $display("[TB] FAIL merge_pf got=%b exp=0", fp_q[0]); end
        end
    endtask

    task automatic test_full_drop();
        logic       to;
        logic [7:0] exp_addr [4];
        exp_addr = '{8'h40, 8'h44, 8'h48, 8'h4C};
        clear_fills();
        mem_req_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            send(1'b1, exp_addr[i], 1'b0, 8'h00);
        end
        checks++;
        if (miss_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_miss_ready got=%b exp=0", miss_ready); end
        send(1'b0, 8'h00, 1'b1, 8'h30);
        checks++;
        if (pf_dropped !== 1'b1) begin failures++; $display("[TB] FAIL full_pf_dropped got=%b exp=1", pf_dropped); end
        step();
        checks++;
        if (pf_dropped !== 1'b0) begin failures++; $display("[TB] FAIL full_pf_dropped_pulse got=%b exp=0", pf_dropped); end
        mem_req_ready = 1'b1;
        for (int n = 0; n < 20 && !fill_valid; n++) begin
            step();
        end
        checks += 2;
        if (fill_valid !== 1'b1) begin failures++; $display("[TB] FAIL full_first_fill_timeout got=%b exp=1", fill_valid); end
        if (miss_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_ready_in_fill got=%b exp=0", miss_ready); end
        step();
        checks++;
        if (miss_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_ready_after_fill got=%b exp=1", miss_ready); end
        wait_idle(100, to);
        checks += 2;
        if (to !== 1'b0) begin failures++; $display("[TB] FAIL full_idle_timeout got=%b exp=0", to); end
        if (fa_q.size() != 4) begin
            failures++;
            $display("[TB] FAIL full_fill_count got=%0d exp=4", fa_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (fa_q[i] !== exp_addr[i] || fp_q[i] !== 1'b0) begin
                    failures++;
                    $display("[TB] FAIL full_order[%0d] got=%h/%b exp=%h/0", i, fa_q[i], fp_q[i], exp_addr[i]);
                end
            end
            checks++;
            if (fd_q[3] !== 32'hC0FFEE4C) begin failures++; $display("[TB] FAIL full_data3 got=%h exp=c0ffee4c", fd_q[3]); end
        end
    endtask

    task automatic test_stall();
        logic to;
        clear_fills();
        mem_req_ready = 1'b0;
        send(1'b1, 8'h55, 1'b0, 8'h00);
        step();
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 8'h55) begin
                failures++;
                $display("[TB] FAIL stall_req[%0d] got=%b/%h exp=1/55", i, mem_req_valid, mem_req_addr);
            end
            step();
        end
        mem_req_ready = 1'b1;
        wait_idle(40, to);
        checks++;
        if (fa_q.size() != 1 || to !== 1'b0) begin
            failures++;
            $display("[TB] FAIL stall_fill_count got=%0d exp=1", fa_q.size());
        end else begin
            checks++;
            if (fa_q[0] !== 8'h55) begin failures++; $display("[TB] FAIL stall_fill_addr got=%h exp=55", fa_q[0]); end
        end
    endtask

    task automatic test_reset_in_wait();
        clear_fills();
        resp_enable   = 1'b0;
        mem_req_ready = 1'b1;
        send(1'b1, 8'h66, 1'b0, 8'h00);
        step();
        step();
        checks += 2;
        if (busy !== 1'b1) begin failures++; $display("[TB] FAIL rst_wait_busy got=%b exp=1", busy); end
        if (mem_req_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_wait_req got=%b exp=0", mem_req_valid); end
        reset = 1'b1;
        #2;
        checks += 2;
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_busy got=%b exp=0", busy); end
        if (miss_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_async_ready got=%b exp=1", miss_ready); end
        step();
        reset          = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h12345678;
        step();
        mem_resp_valid = 1'b0;
        step();
        step();
        checks += 3;
        if (fa_q.size() != 0) begin failures++; $display("[TB] FAIL rst_late_fill got=%0d exp=0", fa_q.size()); end
        if (fill_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_fill_valid got=%b exp=0", fill_valid); end
        if (busy !== 1'b0) begin failures++; $display("[TB] FAIL rst_busy_after got=%b exp=0", busy); end
        resp_enable = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks         = 0;
        failures       = 0;
        cyc            = 0;
        reset          = 1'b1;
        miss_valid     = 1'b0;
        miss_addr      = '0;
        pf_valid       = 1'b0;
        pf_addr        = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;
        resp_enable    = 1'b1;
        test_reset();
        test_single_miss();
        test_miss_and_pf();
        test_merge();
        test_full_drop();
        test_stall();
        test_reset_in_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
